shifter_pipe: RTL and testbench

Parametrised, pipelined successor to the single-stage shift functional unit in the OoO core. It accepts shift ops from the shift reservation station through a valid/ready handshake and spreads the funnel-shifter levels across STAGES pipeline registers. Results are held in an output register until the CDB arbiter grants the broadcast, so back-pressure propagates upstream and no result is lost. It supports a synchronous flush for branch mispredict recovery.

---
 rtl/shifter_pipe.sv | 147 ++++++++++++++
 tb/tb_shifter_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined funnel shifter for the OoO shift unit; results are held for the CDB until granted.
// Optional: define SHIFTER_ROTATE_EN to make RORR/RORI/ROLR/ROLI legal.
package shifter_pipe_pkg;
    typedef enum logic [3:0] {
        SRLR = 4'd0, SRLI, SRAR, SRAI, SLLR, SLLI, RORR, RORI, ROLR, ROLI
    } shift_op_t;

    typedef enum logic [2:0] {
        NO_VAL = 3'd0, ALU_1, ALU_2, SHIFT_1, MUL_1, LSU_1
    } rs_tag_t;
endpackage

module shifter_pipe
    import shifter_pipe_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned STAGES = 2,
    parameter rs_tag_t     TAG    = SHIFT_1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  shift_op_t         oper_i,
    input  logic [DWIDTH-1:0] rs1_val_i,
    input  logic [DWIDTH-1:0] rs2_val_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic              cdb_grant_i,
    output logic              cdb_valid_o,
    output rs_tag_t           cdb_tag_o,
    output logic [DWIDTH-1:0] cdb_val_o,
    output logic              busy_o
);
    localparam int unsigned SW  = $clog2(DWIDTH);
    localparam int unsigned FW  = 2 * DWIDTH;
    localparam int unsigned PER = (SW + STAGES - 1) / STAGES;

    logic [STAGES-1:0] valid_q, valid_d, adv;
    logic [FW-1:0]     fun_q [STAGES];
    logic [FW-1:0]     fun_d [STAGES];
    logic [SW-1:0]     amt_q [STAGES];
    logic [SW-1:0]     amt_d [STAGES];

    logic              legal, left, accept;
    logic [DWIDTH-1:0] hi, lo;
    logic [FW-1:0]     fun_in;
    logic [SW-1:0]     amt_in;
    logic              unused_bits;

    // Apply only the funnel levels that belong to pipeline stage k.
    function automatic logic [FW-1:0] shift_levels(input logic [FW-1:0] f,
                                                   input logic [SW-1:0] amt,
                                                   input int unsigned   k);
        logic [FW-1:0] r;
        r = f;
        for (int unsigned i = 0; i < SW; i++) begin
            if (i >= k * PER && i < (k + 1) * PER && amt[i]) r = r >> (1 << i);
        end
        return r;
    endfunction

    always_comb begin
        legal = 1'b1;
        left  = 1'b0;
        hi    = '0;
        lo    = rs1_val_i;
        case (oper_i)
            SRLR, SRLI: ;
            SRAR, SRAI: hi = {DWIDTH{rs1_val_i[DWIDTH-1]}};
            SLLR, SLLI: begin
                left = 1'b1;
                hi   = rs1_val_i;
                lo   = '0;
            end
`ifdef SHIFTER_ROTATE_EN
            RORR, RORI: hi = rs1_val_i;
            ROLR, ROLI: begin
                left = 1'b1;
                hi   = rs1_val_i;
            end
`endif
            default: legal = 1'b0;
        endcase
    end

    // Left ops pre-shift the funnel right by one so that ~shamt yields DWIDTH-shamt.
    assign amt_in = rs2_val_i[SW-1:0] ^ {SW{left}};
    assign fun_in = left ? {lo[0], hi, lo[DWIDTH-1:1]} : {hi, lo};

    always_comb begin
        logic a;
        a              = ~valid_q[STAGES-1] | cdb_grant_i;
        adv            = '0;
        adv[STAGES-1]  = a;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            a      = ~valid_q[k] | a;
            adv[k] = a;
        end
    end

    assign ready_o = adv[0];
    assign accept  = valid_i & ready_o & ~flush_i;

    always_comb begin
        valid_d = valid_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            fun_d[k] = fun_q[k];
            amt_d[k] = amt_q[k];
        end
        if (adv[0]) begin
            valid_d[0] = accept & legal;
            fun_d[0]   = shift_levels(fun_in, amt_in, 0);
            amt_d[0]   = amt_in;
        end
        for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
                valid_d[k] = valid_q[k-1];
                fun_d[k]   = shift_levels(fun_q[k-1], amt_q[k-1], k);
                amt_d[k]   = amt_q[k-1];
            end
        end
        if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                fun_q[k] <= '0;
                amt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                fun_q[k] <= fun_d[k];
                amt_q[k] <= amt_d[k];
            end
        end
    end

    assign cdb_valid_o = valid_q[STAGES-1];
    assign cdb_tag_o   = cdb_valid_o ? TAG : NO_VAL;
    assign cdb_val_o   = cdb_valid_o ? fun_q[STAGES-1][DWIDTH-1:0] : '0;
    assign busy_o      = |valid_q;

    assign unused_bits = ^{rs2_val_i[DWIDTH-1:SW], fun_q[STAGES-1][FW-1:DWIDTH], amt_q[STAGES-1]};
endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: stimulus pushes expected results, a monitor pops on grant.
module tb_shifter_pipe;
    import shifter_pipe_pkg::*;

    logic        clk, rst_n, valid_i, flush_i, cdb_grant_i;
    shift_op_t   oper_i;
    logic [31:0] rs1_val_i, rs2_val_i, cdb_val_o;
    logic        ready_o, cdb_valid_o, busy_o;
    rs_tag_t     cdb_tag_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    shifter_pipe #(.DWIDTH(32), .STAGES(2), .TAG(SHIFT_1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .oper_i(oper_i),
        .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i), .ready_o(ready_o),
        .flush_i(flush_i), .cdb_grant_i(cdb_grant_i), .cdb_valid_o(cdb_valid_o),
        .cdb_tag_o(cdb_tag_o), .cdb_val_o(cdb_val_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every granted broadcast must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && cdb_valid_o && cdb_grant_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcast: got 0x%0h, expected no broadcast", cdb_val_o);
            end else begin
                check("cdb_val", cdb_val_o, exp_q.pop_front());
                check("cdb_tag", 32'(cdb_tag_o), 32'(SHIFT_1));
            end
        end
    end

    task automatic issue(input shift_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit bc);
        int n = 0;
        valid_i   = 1'b1;
        oper_i    = op;
        rs1_val_i = a;
        rs2_val_i = b;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(ready_o), 32'd1);
        if (ready_o && bc) exp_q.push_back(exp);
        @(posedge clk);
        #1 valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    shift_op_t   v_op [8] = '{SLLR, SRLR, SRAR, SLLI, SRLI, SLLR, SRAR, SRAI};
    logic [31:0] v_a  [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7000_0000, 32'h8000_0001,
                              32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] v_b  [8] = '{32'h23, 32'd31, 32'h24, 32'd0, 32'd8, 32'd31, 32'd31, 32'h20};
    logic [31:0] v_e  [8] = '{32'h0000_0008, 32'h0000_0001, 32'h0700_0000, 32'h8000_0001,
                              32'h0012_3456, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; cdb_grant_i = 1'b0;
        oper_i = SRLR; rs1_val_i = '0; rs2_val_i = '0;
        #3;
        check("rst_valid", 32'(cdb_valid_o), 32'd0);
        check("rst_tag", 32'(cdb_tag_o), 32'(NO_VAL));
        check("rst_val", cdb_val_o, 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);

        // Latency and single-cycle hold with grant high
        @(posedge clk);
        #1 cdb_grant_i = 1'b1;
        issue(SRAI, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);
        @(negedge clk);
        check("lat_early", 32'(cdb_valid_o), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(cdb_valid_o), 32'd1);
        @(negedge clk);
        check("after_tag", 32'(cdb_tag_o), 32'(NO_VAL));
        check("after_val", cdb_val_o, 32'd0);

        // Back-to-back directed vectors
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) issue(v_op[i], v_a[i], v_b[i], v_e[i], 1'b1);
        drain("drain_vectors");

        // Back-pressure: two held, third stalls until grant
        @(posedge clk);
        #1 cdb_grant_i = 1'b0;
        issue(SRLI, 32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b1);
        issue(SLLI, 32'h0000_000F, 32'd4, 32'h0000_00F0, 1'b1);
        valid_i = 1'b1; oper_i = SRAI; rs1_val_i = 32'h8000_0000; rs2_val_i = 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(ready_o), 32'd0);
            check("bp_hold_valid", 32'(cdb_valid_o), 32'd1);
            check("bp_hold_val", cdb_val_o, 32'h0000_000F);
        end
        @(posedge clk);
        #1 cdb_grant_i = 1'b1;
        issue(SRAI, 32'h8000_0000, 32'd1, 32'hC000_0000, 1'b1);
        drain("drain_bp");

        // Flush with two in flight and a same-cycle op
        @(posedge clk);
        #1 cdb_grant_i = 1'b0;
        issue(SLLI, 32'h1, 32'd1, 32'h2, 1'b0);
        issue(SLLI, 32'h1, 32'd2, 32'h4, 1'b0);
        valid_i = 1'b1; oper_i = SLLR; rs1_val_i = 32'h1; rs2_val_i = 32'd3; flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_ready", 32'(ready_o), 32'd1);
        check("flush_valid", 32'(cdb_valid_o), 32'd0);
        #1 valid_i = 1'b1; flush_i = 1'b1; cdb_grant_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        check("flush_drop_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);
        check("flush_no_bcast", 32'(cdb_valid_o), 32'd0);

        // Illegal op consumes the handshake but never broadcasts
        @(posedge clk);
        #1;
        issue(shift_op_t'(4'hF), 32'h1234, 32'd1, 32'h0, 1'b0);
        @(negedge clk);
        check("illegal_busy", 32'(busy_o), 32'd0);

        @(posedge clk);
        #1;
`ifdef SHIFTER_ROTATE_EN
        issue(RORI, 32'h0000_00F1, 32'd4, 32'h1000_000F, 1'b1);
        drain("drain_rotate");
`else
        issue(RORI, 32'h0000_00F1, 32'd4, 32'h1000_000F, 1'b0);
        @(negedge clk);
        check("rotate_off_busy", 32'(busy_o), 32'd0);
`endif

        // Asynchronous reset while a result is pending
        @(posedge clk);
        #1 cdb_grant_i = 1'b0;
        issue(SRLI, 32'h0000_0100, 32'd8, 32'h1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(cdb_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(cdb_valid_o), 32'd0);
        check("async_rst_tag", 32'(cdb_tag_o), 32'(NO_VAL));
        check("async_rst_val", cdb_val_o, 32'd0);
        check("async_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1; cdb_grant_i = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_valid", 32'(cdb_valid_o), 32'd0);
        check("post_rst_ready", 32'(ready_o), 32'd1);

        drain("drain_final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
